// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1/8E1 UART receiver with mid-bit sampling feeding an RX FIFO
module uart_rx #(
    parameter int   SystemClockFreq = 50_000_000,
    parameter int   BaudRate        = 115200,
    parameter logic Parity          = 1'b0,
    parameter logic StopBit         = 1'b1,
    parameter int   DataLength      = 8,
    parameter logic FlowControl     = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx,
    output logic                  o_rts,
    output logic [DataLength-1:0] o_rx_fifo_data,
    output logic                  o_rx_fifo_write_en,
    input  logic                  i_rx_fifo_full,
    output logic                  o_frame_err,
    output logic                  o_parity_err,
    output logic                  o_overrun
);

    localparam int CyclesPerBit = SystemClockFreq / BaudRate;
    localparam int HalfBit      = CyclesPerBit / 2;
    localparam int CntW         = (CyclesPerBit > 2) ? $clog2(CyclesPerBit) : 1;
    localparam int BitW         = (DataLength > 1) ? $clog2(DataLength) : 1;

    localparam logic [CntW-1:0] BitLast  = CntW'(CyclesPerBit - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
    localparam logic [BitW-1:0] DataLast = BitW'(DataLength - 1);
    // Only a single stop bit is checked; StopBit=0 disables the check.
    localparam logic            CheckStop = (StopBit != 1'b0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK,
        ST_WRITE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    rx_meta;
    logic                    rx_s;
    logic [CntW-1:0]         clk_cnt;
    logic [BitW-1:0]         bit_cnt;
    logic [DataLength-1:0]   shift_q;
    logic [DataLength-1:0]   data_q;
    logic                    parity_bad;
    logic                    frame_err_q;
    logic                    rts_q;
    logic                    sample_pt;
    logic                    counting;

    // Two-flop synchronizer; the line idles high so the flops reset to 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Sample point: half a bit into the start bit, one full bit thereafter.
    always_comb begin
        sample_pt = 1'b0;
        counting  = 1'b0;
        case (state)
            ST_START: begin
                counting  = 1'b1;
                sample_pt = (clk_cnt == HalfLast);
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
                counting  = 1'b1;
                sample_pt = (clk_cnt == BitLast);
            end
            default: begin
                counting  = 1'b0;
                sample_pt = 1'b0;
            end
        endcase
    end

    // Frame state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the WRITE-cycle strobes.
    always_comb begin
        state_next         = state;
        o_rx_fifo_write_en = 1'b0;
        o_parity_err       = 1'b0;
        o_overrun          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (sample_pt) begin
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample_pt && (bit_cnt == DataLast)) begin
                    state_next = Parity ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (sample_pt) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_pt) begin
                    state_next = (rx_s || !CheckStop) ? ST_WRITE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_next         = ST_IDLE;
                o_rx_fifo_write_en = !i_rx_fifo_full;
                o_overrun          = i_rx_fifo_full;
                o_parity_err       = parity_bad;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bit-period counter: restarts on every state change and at each sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_cnt <= '0;
        end else if ((state_next != state) || sample_pt) begin
            clk_cnt <= '0;
        end else if (counting) begin
            clk_cnt <= clk_cnt + CntW'(1);
        end
    end

    // Data bit index, only meaningful while in DATA.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt <= '0;
        end else if (state != ST_DATA) begin
            bit_cnt <= '0;
        end else if (sample_pt) begin
            bit_cnt <= bit_cnt + BitW'(1);
        end
    end

    // LSB arrives first, so shift right and insert at the MSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
        end else if ((state == ST_DATA) && sample_pt) begin
            shift_q <= {rx_s, shift_q[DataLength-1:1]};
        end
    end

    // Even parity: data bits plus parity bit must have an even count of ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            parity_bad <= 1'b0;
        end else if (state == ST_START) begin
            parity_bad <= 1'b0;
        end else if ((state == ST_PARITY) && sample_pt) begin
            parity_bad <= (^shift_q) ^ rx_s;
        end
    end

    // Output byte only moves when a frame leaves STOP with a good stop bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= '0;
        end else if ((state == ST_STOP) && (state_next == ST_WRITE)) begin
            data_q <= shift_q;
        end
    end

    // Framing error pulses once, the cycle after a low stop bit is seen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= (state == ST_STOP) && (state_next == ST_BREAK);
        end
    end

    // Ready-to-receive follows FIFO space when flow control is on.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rts_q <= 1'b0;
        end else begin
            rts_q <= FlowControl ? !i_rx_fifo_full : 1'b1;
        end
    end

    assign o_rx_fifo_data = data_q;
    assign o_frame_err    = frame_err_q;
    assign o_rts          = rts_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against an event-level model
module tb_uart_rx;

    localparam int Cpb  = 16;
    localparam int Half = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx0, rx1, full0, full1;
    logic       rts0, rts1, we0, we1, fe0, fe1, pe0, pe1, ov0, ov1;
    logic [7:0] data0, data1;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    int obs_ev[$];
    int obs_cy[$];
    int exp_ev[$];
    int exp_cy[$];

    uart_rx #(
        .SystemClockFreq(16), .BaudRate(1), .Parity(1'b0),
        .StopBit(1'b1), .DataLength(8), .FlowControl(1'b0)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx0), .o_rts(rts0),
        .o_rx_fifo_data(data0), .o_rx_fifo_write_en(we0),
        .i_rx_fifo_full(full0), .o_frame_err(fe0),
        .o_parity_err(pe0), .o_overrun(ov0)
    );

    uart_rx #(
        .SystemClockFreq(16), .BaudRate(1), .Parity(1'b1),
        .StopBit(1'b1), .DataLength(8), .FlowControl(1'b1)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx1), .o_rts(rts1),
        .o_rx_fifo_data(data1), .o_rx_fifo_write_en(we1),
        .i_rx_fifo_full(full1), .o_frame_err(fe1),
        .o_parity_err(pe1), .o_overrun(ov1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ev(input int sel, input int kind, input int data);
        return (sel << 12) | (kind << 8) | (data & 8'hFF);
    endfunction

    // Event log: kind 1 write, 2 frame error, 3 parity error, 4 overrun.
    always @(negedge clk) begin
        if (we0) begin obs_ev.push_back(ev(0, 1, int'(data0))); obs_cy.push_back(cyc); end
        if (fe0) begin obs_ev.push_back(ev(0, 2, 0)); obs_cy.push_back(cyc); end
        if (pe0) begin obs_ev.push_back(ev(0, 3, 0)); obs_cy.push_back(cyc); end
        if (ov0) begin obs_ev.push_back(ev(0, 4, 0)); obs_cy.push_back(cyc); end
        if (we1) begin obs_ev.push_back(ev(1, 1, int'(data1))); obs_cy.push_back(cyc); end
        if (fe1) begin obs_ev.push_back(ev(1, 2, 0)); obs_cy.push_back(cyc); end
        if (pe1) begin obs_ev.push_back(ev(1, 3, 0)); obs_cy.push_back(cyc); end
        if (ov1) begin obs_ev.push_back(ev(1, 4, 0)); obs_cy.push_back(cyc); end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int sel, input logic v, input int n);
        if (sel == 0) rx0 = v; else rx1 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void expect_ev(input int e, input int c);
        exp_ev.push_back(e);
        exp_cy.push_back(c);
    endfunction

    // Sends one frame and records what the line rules say must come out.
    task automatic send(input int sel, input logic [7:0] data, input logic pbit,
                        input int stop_low, input logic full);
        int  has_par;
        int  ec;
        bit  bad;
        has_par = sel;
        if (sel == 0) full0 = full; else full1 = full;
        ec  = cyc + 2 + Half + (8 + has_par + 1) * Cpb + 1;
        bad = (has_par != 0) && ((($countones(data) + int'(pbit)) % 2) != 0);
        if (stop_low > 0) begin
            expect_ev(ev(sel, 2, 0), ec);
        end else begin
            if (!full) expect_ev(ev(sel, 1, int'(data)), ec);
            if (bad)   expect_ev(ev(sel, 3, 0), ec);
            if (full)  expect_ev(ev(sel, 4, 0), ec);
        end
        hold(sel, 1'b0, Cpb);
        for (int i = 0; i < 8; i++) hold(sel, data[i], Cpb);
        if (has_par != 0) hold(sel, pbit, Cpb);
        if (stop_low > 0) hold(sel, 1'b0, stop_low);
        hold(sel, 1'b1, Cpb);
    endtask

    task automatic verify(input string tag);
        repeat (40) @(posedge clk);
        #1;
        check({tag, "_count"}, obs_ev.size(), exp_ev.size());
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) begin
            check({tag, "_event"}, obs_ev[i], exp_ev[i]);
            check({tag, "_cycle"}, obs_cy[i], exp_cy[i]);
        end
        obs_ev.delete(); obs_cy.delete();
        exp_ev.delete(); exp_cy.delete();
    endtask

    initial begin
        logic [7:0] rdata;
        int         rsel;
        logic       rfull;
        logic       rpbit;

        rst_n = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1; full0 = 1'b0; full1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data0", int'(data0), 0);
        check("reset_rts", int'({rts0, rts1}), 0);
        check("reset_pulses", int'({we0, fe0, pe0, ov0, we1, fe1, pe1, ov1}), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rts_after_reset", int'({rts0, rts1}), 3);

        send(0, 8'hA5, 1'b0, 0, 1'b0);
        verify("a5");

        send(0, 8'h00, 1'b0, 0, 1'b0);
        send(0, 8'hFF, 1'b0, 0, 1'b0);
        verify("back_to_back");

        hold(0, 1'b0, 4);
        hold(0, 1'b1, 30);
        verify("glitch");

        send(0, 8'h3C, 1'b0, 40, 1'b0);
        send(0, 8'h81, 1'b0, 0, 1'b0);
        verify("break_then_81");

        send(1, 8'h07, 1'b0, 0, 1'b0);
        send(1, 8'h07, 1'b1, 0, 1'b0);
        verify("parity");

        send(0, 8'h55, 1'b0, 0, 1'b1);
        full0 = 1'b0;
        verify("overrun");

        // Flow control: o_rts tracks full one cycle late on dut1, stays high on dut0.
        full1 = 1'b1; full0 = 1'b1;
        @(negedge clk);
        check("rts_before_full", int'(rts1), 1);
        @(negedge clk);
        check("rts_full", int'(rts1), 0);
        check("rts_no_flow", int'(rts0), 1);
        @(posedge clk);
        #1;
        full1 = 1'b0; full0 = 1'b0;
        @(negedge clk);
        check("rts_still_low", int'(rts1), 0);
        @(negedge clk);
        check("rts_released", int'(rts1), 1);

        // Reset in the middle of the data bits of 0xF0.
        @(posedge clk);
        #1;
        hold(0, 1'b0, Cpb);
        for (int i = 0; i < 4; i++) hold(0, 1'b0, Cpb);
        hold(0, 1'b1, 8);
        rst_n = 1'b0;
        rx0 = 1'b1;
        #1;
        check("midreset_data", int'(data0), 0);
        check("midreset_rts", int'(rts0), 0);
        check("midreset_pulses", int'({we0, fe0, pe0, ov0}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(0, 1'b1, 5);
        verify("reset_abort");
        send(0, 8'h12, 1'b0, 0, 1'b0);
        verify("after_reset");

        for (int k = 0; k < 12; k++) begin
            rsel  = int'($urandom_range(0, 1));
            rdata = 8'($urandom);
            rfull = ($urandom_range(0, 3) == 0);
            rpbit = (rsel == 1) ? ((^rdata) ^ ($urandom_range(0, 2) == 0)) : 1'b0;
            send(rsel, rdata, rpbit, 0, rfull);
            hold(rsel, 1'b1, int'($urandom_range(0, 20)));
        end
        full0 = 1'b0; full1 = 1'b0;
        verify("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the team's FIFO-fed UART transmitter. Recovers 8N1 (optionally 8E1) frames from the serial line using mid-bit sampling. Pushes each good byte into a downstream RX FIFO through a single-cycle write strobe. Flags framing, parity and overrun errors, and drives RTS when flow control is enabled.

Parameters:
SystemClockFreq, 50_000_000, i_clk frequency in Hz
BaudRate, 115200, line bit rate; CyclesPerBit = SystemClockFreq / BaudRate (integer divide), HalfBit = CyclesPerBit / 2
Parity, 1'b0, 1 = one even-parity bit expected after the data bits
StopBit, 1'b1, number of stop bits checked (only 1 supported)
DataLength, 8, data bits per frame, LSB first
FlowControl, 1'b0, 1 = drive o_rts from FIFO space; 0 = o_rts held 1 after reset

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_rx  input  1  serial line, asynchronous, idle high
o_rts  output  1  active-high "ready to receive"; = !i_rx_fifo_full when FlowControl=1, registered
o_rx_fifo_data  output  DataLength  received byte; valid while o_rx_fifo_write_en=1
o_rx_fifo_write_en  output  1  one-cycle push strobe to RX FIFO
i_rx_fifo_full  input  1  RX FIFO full
o_frame_err  output  1  one-cycle pulse: stop bit sampled 0
o_parity_err  output  1  one-cycle pulse: parity mismatch (byte still written)
o_overrun  output  1  one-cycle pulse: good byte dropped because FIFO full

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; synchronizer flops = 1; shift register, counters, o_rx_fifo_data = 0; o_rx_fifo_write_en, o_frame_err, o_parity_err, o_overrun, o_rts = 0. Reset mid-frame abandons the frame; no write or error pulse follows.
- i_rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- clk_counter: cleared on every state entry. Increments each cycle while in START/DATA/PARITY/STOP, wraps to 0 at the sample point. bit_counter: counts 0..DataLength-1 in DATA; cleared outside DATA.
- IDLE: rx_s=0 -> START.
- START: at clk_counter==HalfBit-1, sample rx_s. 0 -> DATA; 1 -> IDLE (glitch rejected, no error pulse).
- DATA: at clk_counter==CyclesPerBit-1, shift rx_s into the MSB, shifting right (LSB first on line). After bit DataLength-1: -> PARITY if Parity=1, else -> STOP.
- PARITY: at CyclesPerBit-1, store parity_bad = ^data ^ rx_s. -> STOP.
- STOP: at CyclesPerBit-1, sample rx_s.
  - 1 -> WRITE.
  - 0 -> pulse o_frame_err next cycle, discard byte, -> BREAK.
- BREAK: wait for rx_s=1, then -> IDLE. A held-low line produces exactly one o_frame_err.
- WRITE (exactly 1 cycle, then -> IDLE):
  - i_rx_fifo_full=0: o_rx_fifo_write_en=1 with o_rx_fifo_data = shifted byte.
  - i_rx_fifo_full=1: write_en=0, o_overrun=1.
  - o_parity_err=1 in the same cycle if parity_bad, regardless of the full/not-full outcome.
- o_rx_fifo_data is held from a register and changes only on STOP exit.
- Latency: with rx_s first low at cycle T, write_en asserts at T + HalfBit + (DataLength+Parity+1)*CyclesPerBit + 1.
- Back-to-back frames: the start edge of the next frame is detected because WRITE takes 1 cycle and IDLE is entered before the half-bit point of that start bit.
- o_rts: registered. FlowControl=1: o_rts <= !i_rx_fifo_full. FlowControl=0: o_rts <= 1.

Test Plan:
- Use CyclesPerBit=16 (SystemClockFreq=16, BaudRate=1), Parity=0 unless stated. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> single write_en pulse, data=0xA5, no error pulses; latency matches formula.
- Back-to-back frames 0x00 then 0xFF with zero idle between stop and start -> two write_en pulses, data 0x00 then 0xFF.
- Low glitch of 4 cycles on idle line -> returns to IDLE, no write, no errors. Frame 0x3C with stop bit driven 0 for 40 cycles -> one o_frame_err, no write; next valid frame 0x81 received correctly.
- Parity=1: send 0x07 with parity bit 0 (even parity expects 1) -> write_en with 0x07 plus o_parity_err in the same cycle. Send 0x07 with parity bit 1 -> no error.
- i_rx_fifo_full=1 during frame 0x55 -> o_overrun pulse, no write_en. FlowControl=1 -> o_rts=0 one cycle after full rises, back to 1 one cycle after full falls.
- Assert i_rst_n=0 mid-DATA of 0xF0 -> all outputs 0 immediately. After release, frame 0x12 received correctly with no spurious pulses.
